// File: rtl/program_counter_pkg.sv
// Shared definitions for the program counter: default width, reset value, bit-level mux.
// Latency: none (declarations only).
// Backpressure: none.
package program_counter_pkg;

  // Default counter / instruction-address width.
  localparam int PC_WIDTH = 16;

  // Value forced into the counter by reset, replicated to whatever width is in use.
  localparam logic PC_RESET_BIT = 1'b0;

  // Two-input bit mux: a when sel=0, b when sel=1.
  function automatic logic mux_bit(input logic a, input logic b, input logic sel);
    return sel ? b : a;
  endfunction

endpackage

// File: rtl/program_counter_register_w.sv
// WIDTH-bit register of Bit cells: one mux (hold/take) plus one flop per bit.
// Latency: 1 cycle from in/load to out.
// Backpressure: none; captures every rising edge of clock.
module register_w
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] bit_d;
  logic [WIDTH-1:0] bit_q;

  // Per-bit select between recirculating the stored bit and taking the new one.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bit_d[i] = mux_bit(bit_q[i], in[i], load);
  end

  // Storage flops; no reset of their own, reset arrives through the data path.
  always_ff @(posedge clock) begin
    bit_q <= bit_d;
  end

  assign out = bit_q;

endmodule

// File: rtl/program_counter.sv
// Program counter: each edge resets to 0, loads a jump target, increments, or holds.
// Latency: 1 cycle from sampled controls to out; out is purely registered.
// Backpressure: none; controls are sampled every rising edge of clock.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] m2;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] reset_val;

  assign reset_val = {WIDTH{PC_RESET_BIT}};

  // Unsigned WIDTH-bit incrementer; the carry out of the top bit is dropped so
  // all-ones wraps to zero.
  assign pc_inc = pc_q + WIDTH'(1);

  // Mux chain ordered so that later stages win: inc < load < reset.
  for (genvar i = 0; i < WIDTH; i++) begin : g_sel
    assign m1[i]   = mux_bit(pc_q[i], pc_inc[i], inc);
    assign m2[i]   = mux_bit(m1[i], in[i], load);
    assign pc_d[i] = mux_bit(m2[i], reset_val[i], reset);
  end

  // Counter state; load is tied high so the register takes the mux-chain result every edge.
  register_w #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clock (clock),
    .in    (pc_d),
    .load  (1'b1),
    .out   (pc_q)
  );

  assign out = pc_q;

endmodule
